regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_wb_out_stage.sv | 53 +++++
 rtl/regfile_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and grant encoding for the register-file writeback arbiter.
// Optional round-robin policy is selected with the WB_ARB_RR_EN macro.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        GNT_MEM = 1'b0,
        GNT_ALU = 1'b1
    } gnt_sel_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_out_stage.sv
// Registered register-file write port: captures the accepted transfer and
// drops writes to x0. Index and data hold their value when nothing is written.
module wb_out_stage
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = regfile_wb_arbiter_pkg::DATA_W,
    parameter int ADDR_W = regfile_wb_arbiter_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              xfer_valid,
    input  logic [ADDR_W-1:0] xfer_rd,
    input  logic [DATA_W-1:0] xfer_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rw,
    output logic [DATA_W-1:0] rf_din
);

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_rw_q, rf_rw_d;
    logic [DATA_W-1:0] rf_din_q, rf_din_d;
    logic              do_write;

    // A transfer to x0 is still accepted upstream but never reaches the file.
    assign do_write = xfer_valid && (xfer_rd != ADDR_W'(REG_ZERO));

    always_comb begin
        rf_we_d  = do_write;
        rf_rw_d  = rf_rw_q;
        rf_din_d = rf_din_q;
        if (do_write) begin
            rf_rw_d  = xfer_rd;
            rf_din_d = xfer_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q  <= 1'b0;
            rf_rw_q  <= '0;
            rf_din_q <= '0;
        end else begin
            rf_we_q  <= rf_we_d;
            rf_rw_q  <= rf_rw_d;
            rf_din_q <= rf_din_d;
        end
    end

    assign rf_we  = rf_we_q;
    assign rf_rw  = rf_rw_q;
    assign rf_din = rf_din_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writeback onto the single register-file write port.
// Default: memory priority with ALU starvation guard; WB_ARB_RR_EN selects round-robin.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = regfile_wb_arbiter_pkg::DATA_W,
    parameter int ADDR_W     = regfile_wb_arbiter_pkg::ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rw,
    output logic [DATA_W-1:0] rf_din,
    output logic              alu_starved
);

    // Handshake: a request transfers in the cycle where valid & ready are both
    // high; the requester holds valid/rd/data stable until then. Ready depends
    // combinationally on both valids and arbitration state, never on the reverse.

    gnt_sel_e          gnt_sel;
    logic              any_gnt;
    logic              force_alu;
    logic [ADDR_W-1:0] xfer_rd;
    logic [DATA_W-1:0] xfer_data;

`ifdef WB_ARB_RR_EN
    gnt_sel_e last_grant_q, last_grant_d;

    assign force_alu = 1'b0;

    always_comb begin
        last_grant_d = last_grant_q;
        if (any_gnt) begin
            last_grant_d = gnt_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GNT_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign force_alu = (starve_cnt_q == CNT_W'(STARVE_MAX));

    // Counts consecutive cycles the ALU waited; any non-waiting cycle clears it.
    always_comb begin
        starve_cnt_d = '0;
        if (alu_valid && !alu_ready) begin
            starve_cnt_d = force_alu ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    always_comb begin
        gnt_sel     = GNT_MEM;
        any_gnt     = 1'b0;
        alu_starved = 1'b0;
        if (!reset) begin
            if (mem_valid && alu_valid) begin
                any_gnt = 1'b1;
`ifdef WB_ARB_RR_EN
                gnt_sel = (last_grant_q == GNT_MEM) ? GNT_ALU : GNT_MEM;
`else
                if (force_alu) begin
                    gnt_sel     = GNT_ALU;
                    alu_starved = 1'b1;
                end
`endif
            end else if (mem_valid) begin
                any_gnt = 1'b1;
                gnt_sel = GNT_MEM;
            end else if (alu_valid) begin
                any_gnt = 1'b1;
                gnt_sel = GNT_ALU;
            end
        end
    end

    assign alu_ready = any_gnt && (gnt_sel == GNT_ALU);
    assign mem_ready = any_gnt && (gnt_sel == GNT_MEM);
    assign xfer_rd   = (gnt_sel == GNT_ALU) ? alu_rd : mem_rd;
    assign xfer_data = (gnt_sel == GNT_ALU) ? alu_data : mem_data;

    wb_out_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_out (
        .clk        (clk),
        .reset      (reset),
        .xfer_valid (any_gnt),
        .xfer_rd    (xfer_rd),
        .xfer_data  (xfer_data),
        .rf_we      (rf_we),
        .rf_rw      (rf_rw),
        .rf_din     (rf_din)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter with a queue-based
// scoreboard of expected register-file writes.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SM = 4;
    localparam int EW = AW + DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alu_valid = 1'b0, mem_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0, mem_rd = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0;
    logic          alu_ready, mem_ready, alu_starved;
    logic          rf_we;
    logic [AW-1:0] rf_rw;
    logic [DW-1:0] rf_din;

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];

    // Reference state: consecutive cycles the ALU has been kept waiting, and
    // who won the last grant (used by the round-robin policy).
    int alu_wait = 0;
    int last_alu = 0;
    logic prev_rst = 1'b0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .STARVE_MAX (SM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .rf_we       (rf_we),
        .rf_rw       (rf_rw),
        .rf_din      (rf_din),
        .alu_starved (alu_starved)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected one,
    // exactly one cycle after the transfer that produced it.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got rw=%0d din=%h expected no write at %0t",
                         rf_rw, rf_din, $time);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if ({rf_rw, rf_din} === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL write_data: got rw=%0d din=%h expected rw=%0d din=%h at %0t",
                             rf_rw, rf_din, e[EW-1:DW], e[DW-1:0], $time);
                end
            end
        end else if (exp_q.size() != 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL write_missing: got rf_we=%b expected write rw=%0d din=%h at %0t",
                     rf_we, e[EW-1:DW], e[DW-1:0], $time);
        end
    end

    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                         input logic rst, output logic ga, output logic gm);
        logic exp_a, exp_m, exp_s;
        @(negedge clk);
        if (prev_rst) begin
            check("rst_rf_we", 64'(rf_we), 64'(0));
            check("rst_rf_rw", 64'(rf_rw), 64'(0));
            check("rst_rf_din", 64'(rf_din), 64'(0));
        end
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        reset = rst;
        #1;
        exp_a = 1'b0; exp_m = 1'b0; exp_s = 1'b0;
        if (!rst) begin
            if (av && mv) begin
`ifdef WB_ARB_RR_EN
                exp_a = (last_alu == 0);
`else
                exp_a = (alu_wait >= SM);
                exp_s = exp_a;
`endif
                exp_m = !exp_a;
            end else begin
                exp_a = av;
                exp_m = mv;
            end
        end
        check("alu_ready", 64'(alu_ready), 64'(exp_a));
        check("mem_ready", 64'(mem_ready), 64'(exp_m));
        check("alu_starved", 64'(alu_starved), 64'(exp_s));
        if (exp_a && ard != '0) exp_q.push_back({ard, ad});
        if (exp_m && mrd != '0) exp_q.push_back({mrd, md});
        if (rst) begin
            alu_wait = 0;
            last_alu = 0;
        end else begin
            if (av && !exp_a) alu_wait = (alu_wait < SM) ? alu_wait + 1 : SM;
            else alu_wait = 0;
            if (exp_a) last_alu = 1;
            else if (exp_m) last_alu = 0;
        end
        prev_rst = rst;
        ga = exp_a;
        gm = exp_m;
    endtask

    task automatic idle(input int n);
        logic ga, gm;
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, ga, gm);
    endtask

    initial begin
        logic          ga, gm;
        logic          pa, pm;
        logic [AW-1:0] pa_rd, pm_rd;
        logic [DW-1:0] pa_d, pm_d;

        // Reset held two cycles with both requesters asking.
        drive(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b1, ga, gm);
        drive(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b1, ga, gm);

        // Single ALU write.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, ga, gm);
        idle(2);

        // Continuous load traffic against a waiting ALU: four loads, then forced ALU.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd3, 32'h3333_3333, 1'b1, AW'(10 + i), 32'hA000_0000 + i, 1'b0, ga, gm);
        end
        // Counter cleared: contention goes back to memory.
        drive(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd20, 32'h2020_2020, 1'b0, ga, gm);
        drive(1'b1, 5'd4, 32'h4444_4444, 1'b0, '0, '0, 1'b0, ga, gm);

        // Load to x0 is accepted but not written.
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, ga, gm);
        idle(1);

        // Same destination: load first, then the held ALU result.
        drive(1'b1, 5'd7, 32'h0000_BBBB, 1'b1, 5'd7, 32'h0000_AAAA, 1'b0, ga, gm);
        drive(1'b1, 5'd7, 32'h0000_BBBB, 1'b0, '0, '0, 1'b0, ga, gm);
        idle(1);

        // Reset mid-operation.
        drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h9999_0009, 1'b0, ga, gm);
        drive(1'b1, 5'd8, 32'h8888_0008, 1'b1, 5'd9, 32'h9999_0009, 1'b1, ga, gm);
        idle(1);

        // Randomized traffic; each requester holds its request until granted.
        pa = 1'b0; pm = 1'b0;
        pa_rd = '0; pm_rd = '0; pa_d = '0; pm_d = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && $urandom_range(0, 99) < 60) begin
                pa = 1'b1; pa_rd = AW'($urandom_range(0, 31)); pa_d = $urandom();
            end
            if (!pm && $urandom_range(0, 99) < 70) begin
                pm = 1'b1; pm_rd = AW'($urandom_range(0, 31)); pm_d = $urandom();
            end
            drive(pa, pa_rd, pa_d, pm, pm_rd, pm_d, ($urandom_range(0, 79) == 0), ga, gm);
            if (ga) pa = 1'b0;
            if (gm) pm = 1'b0;
        end

        idle(3);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
